// File: rtl/siso_layer_scheduler.sv
// siso_layer_scheduler
// Read-side initiator for the pipelined SISO row unit of a layered LDPC decoder.
// Sweeps each layer's addresses, then holds off the next layer until every
// write-back of the current layer has been seen, so that a later read cannot
// overtake an LLR write it depends on. Repeats for MAXITER iterations and
// then pulses done.
// Optional feature: define SCHED_EARLY_TERM_EN to finish at the end of any
// iteration in which syndrome_ok is high.
module siso_layer_scheduler #(
    parameter int ADDRWIDTH = 5,
    parameter int ADDRDEPTH = 20,
    parameter int LAYERS    = 2,
    parameter int MAXITER   = 8,
    parameter int ITERBITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 wren_in,
    input  logic                 wrlayer_in,
    input  logic [ADDRWIDTH-1:0] wraddress_in,
    input  logic                 syndrome_ok,
    output logic                 rdlayer,
    output logic [ADDRWIDTH-1:0] rdaddress,
    output logic                 rden_LLR,
    output logic                 rden_E,
    output logic                 busy,
    output logic                 done,
    output logic [ITERBITS-1:0]  iter_count,
    output logic                 err
);

    localparam logic [ADDRWIDTH:0]   L_DEPTH      = (ADDRWIDTH+1)'(ADDRDEPTH);
    localparam logic [ADDRWIDTH-1:0] L_LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
    localparam logic                 L_LAST_LAYER = 1'(LAYERS - 1);
    localparam logic [ITERBITS-1:0]  L_MAXITER    = ITERBITS'(MAXITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_layer;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic                  r_rden;
    logic [ADDRWIDTH:0]    r_wb_cnt;
    logic [ITERBITS-1:0]   r_iter;
    logic                  r_err;

    logic                  w_last_addr;
    logic                  w_wb_full;
    logic                  w_last_layer;
    logic [ITERBITS-1:0]   w_iter_inc;
    logic                  w_finish;
    logic                  w_tracking;
    logic                  w_wb_mismatch;
    logic                  w_busy;
    logic                  w_done;

    assign w_last_addr   = (r_addr == L_LAST_ADDR);
    assign w_wb_full     = (r_wb_cnt == L_DEPTH);
    assign w_last_layer  = (r_layer == L_LAST_LAYER);
    assign w_iter_inc    = r_iter + 1'b1;
    assign w_tracking    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_wb_mismatch = ({1'b0, wraddress_in} != r_wb_cnt) || (wrlayer_in != r_layer);

`ifdef SCHED_EARLY_TERM_EN
    assign w_finish = (w_iter_inc == L_MAXITER) || syndrome_ok;
`else
    logic w_unused_syndrome;
    assign w_unused_syndrome = syndrome_ok;
    assign w_finish = (w_iter_inc == L_MAXITER);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (w_last_addr) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_wb_full) begin
                    if (!w_last_layer) begin
                        w_state_nxt = S_ISSUE;
                    end else if (w_finish) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read sweep, layer/iteration counters and write-back tracking.
    // The write-back block sits after the sweep so that a stray strobe in the
    // same cycle as an accepted start still raises err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer  <= 1'b0;
            r_addr   <= '0;
            r_rden   <= 1'b0;
            r_wb_cnt <= '0;
            r_iter   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_layer  <= 1'b0;
                        r_addr   <= '0;
                        r_rden   <= 1'b1;
                        r_wb_cnt <= '0;
                        r_iter   <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_last_addr) begin
                        r_rden <= 1'b0;
                        r_addr <= '0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_wb_full) begin
                        r_wb_cnt <= '0;
                        r_addr   <= '0;
                        r_rden   <= (w_state_nxt == S_ISSUE);
                        if (w_last_layer) begin
                            r_layer <= 1'b0;
                            r_iter  <= w_iter_inc;
                        end else begin
                            r_layer <= r_layer + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (wren_in) begin
                if (w_tracking && !w_wb_full) begin
                    r_wb_cnt <= r_wb_cnt + 1'b1;
                    if (w_wb_mismatch) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign rdlayer    = r_layer;
    assign rdaddress  = r_addr;
    assign rden_LLR   = r_rden;
    assign rden_E     = r_rden;
    assign busy       = w_busy;
    assign done       = w_done;
    assign iter_count = r_iter;
    assign err        = r_err;

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Directed bench for siso_layer_scheduler. Instance u_dut0 runs MAXITER=2 for
// the sweep / drain / error / reset scenarios; u_dut1 runs MAXITER=8 for the
// iteration-count scenario (3 with SCHED_EARLY_TERM_EN, 8 without).
// A row-unit model echoes each read back as a write-back after `delay` cycles.
module tb_siso_layer_scheduler;

    localparam int AW    = 5;
    localparam int DEPTH = 20;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic          rst, start0, start1, syn0, syn1;
    logic          wren0, wrl0, wren1, wrl1;
    logic [AW-1:0] wra0, wra1;
    logic          rdl0, rdenL0, rdenE0, busy0, done0, err0;
    logic          rdl1, rdenL1, rdenE1, busy1, done1, err1;
    logic [AW-1:0] rda0, rda1;
    logic [3:0]    iter0, iter1;

    siso_layer_scheduler #(.ADDRWIDTH(AW), .ADDRDEPTH(DEPTH), .LAYERS(2), .MAXITER(2), .ITERBITS(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .wren_in(wren0), .wrlayer_in(wrl0),
        .wraddress_in(wra0), .syndrome_ok(syn0), .rdlayer(rdl0), .rdaddress(rda0),
        .rden_LLR(rdenL0), .rden_E(rdenE0), .busy(busy0), .done(done0),
        .iter_count(iter0), .err(err0)
    );

    siso_layer_scheduler #(.ADDRWIDTH(AW), .ADDRDEPTH(DEPTH), .LAYERS(2), .MAXITER(8), .ITERBITS(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .wren_in(wren1), .wrlayer_in(wrl1),
        .wraddress_in(wra1), .syndrome_ok(syn1), .rdlayer(rdl1), .rdaddress(rda1),
        .rden_LLR(rdenL1), .rden_E(rdenE1), .busy(busy1), .done(done1),
        .iter_count(iter1), .err(err1)
    );

    int   errors = 0;
    int   checks = 0;

    // Controls written only by the main sequence
    int   delay     = 12;
    logic corrupt   = 1'b0;
    int   clr_req   = 0;
    int   stray_req = 0;

    // Statistics written only by the model process
    int n_reads, seq_bad, hazard, n_done, n_wb, e_bad;
    int n_reads1, n_done1, seq_bad1;

    typedef struct {
        int          due;
        logic        l;
        logic [AW-1:0] a;
    } wb_t;

    // Row-unit model: one process owns the write-back strobes and statistics
    initial begin
        wb_t q0[$];
        wb_t q1[$];
        wb_t e;
        int  cyc_n      = 0;
        int  clr_seen   = 0;
        int  stray_seen = 0;
        wren0 = 1'b0; wrl0 = 1'b0; wra0 = '0;
        wren1 = 1'b0; wrl1 = 1'b0; wra1 = '0;
        n_reads = 0; seq_bad = 0; hazard = 0; n_done = 0; n_wb = 0; e_bad = 0;
        n_reads1 = 0; n_done1 = 0; seq_bad1 = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                q0.delete(); q1.delete();
                n_reads = 0; seq_bad = 0; hazard = 0; n_done = 0; n_wb = 0; e_bad = 0;
                n_reads1 = 0; n_done1 = 0; seq_bad1 = 0;
            end
            wren0 = 1'b0; wrl0 = 1'b0; wra0 = '0;
            wren1 = 1'b0; wrl1 = 1'b0; wra1 = '0;
            if (q0.size() > 0 && q0[0].due == cyc_n) begin
                e = q0.pop_front();
                wren0 = 1'b1;
                wrl0  = e.l;
                wra0  = (corrupt && n_wb == 4) ? AW'(7) : e.a;
                n_wb++;
            end else if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                wren0 = 1'b1;
            end
            if (q1.size() > 0 && q1[0].due == cyc_n) begin
                e = q1.pop_front();
                wren1 = 1'b1;
                wrl1  = e.l;
                wra1  = e.a;
            end
            if (rdenL0 === 1'b1) begin
                if (q0.size() > 0 && q0[0].l != rdl0) hazard++;
                if (int'(rda0) != n_reads % DEPTH || int'(rdl0) != (n_reads / DEPTH) % 2) seq_bad++;
                n_reads++;
                e.due = cyc_n + delay; e.l = rdl0; e.a = rda0;
                q0.push_back(e);
            end
            if (rdenL1 === 1'b1) begin
                if (int'(rda1) != n_reads1 % DEPTH || int'(rdl1) != (n_reads1 / DEPTH) % 2) seq_bad1++;
                n_reads1++;
                e.due = cyc_n + delay; e.l = rdl1; e.a = rda1;
                q1.push_back(e);
            end
            if (rdenE0 !== rdenL0 || rdenE1 !== rdenL1) e_bad++;
            if (done0 === 1'b1) n_done++;
            if (done1 === 1'b1) n_done1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic clr_model();
        clr_req++;
        cyc();
    endtask

    task automatic wait_done0(input int bound);
        int n = 0;
        while (done0 !== 1'b1 && n < bound) begin
            cyc();
            n++;
        end
        check("done0_seen", 32'(done0), 32'd1);
    endtask

    task automatic wait_done1(input int bound);
        int n = 0;
        while (done1 !== 1'b1 && n < bound) begin
            cyc();
            n++;
        end
        check("done1_seen", 32'(done1), 32'd1);
    endtask

    initial begin
        int n;
        int exp_iter;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; syn0 = 1'b0; syn1 = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_rden",  32'(rdenL0), 32'd0);
        check("rst_rdenE", 32'(rdenE0), 32'd0);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_done",  32'(done0),  32'd0);
        check("rst_err",   32'(err0),   32'd0);
        check("rst_iter",  32'(iter0),  32'd0);
        check("rst_addr",  32'(rda0),   32'd0);
        rst = 1'b0;
        cyc();

        // Nominal run, latency 12, with an ignored start while busy
        clr_model();
        delay = 12;
        start0 = 1'b1; cyc(); start0 = 1'b0;
        check("first_rden",  32'(rdenL0), 32'd1);
        check("first_addr",  32'(rda0),   32'd0);
        check("first_layer", 32'(rdl0),   32'd0);
        check("first_busy",  32'(busy0),  32'd1);
        repeat (30) cyc();
        start0 = 1'b1; cyc(); start0 = 1'b0;
        wait_done0(1000);
        check("done_busy", 32'(busy0), 32'd0);
        start0 = 1'b1; cyc(); start0 = 1'b0;
        check("done_pulse_1cyc",  32'(done0),  32'd0);
        check("start_in_done_ign", 32'(busy0), 32'd0);
        check("after_done_rden",  32'(rdenL0), 32'd0);
        cyc();
        check("nom_reads",   32'(n_reads), 32'd80);
        check("nom_seq",     32'(seq_bad), 32'd0);
        check("nom_hazard",  32'(hazard),  32'd0);
        check("nom_ndone",   32'(n_done),  32'd1);
        check("nom_iter",    32'(iter0),   32'd2);
        check("nom_err",     32'(err0),    32'd0);
        check("rdenE_equal", 32'(e_bad),   32'd0);

        // Drain hold, latency 30
        clr_model();
        delay = 30;
        start0 = 1'b1; cyc(); start0 = 1'b0;
        wait_done0(2000);
        cyc();
        check("drain_reads",  32'(n_reads), 32'd80);
        check("drain_hazard", 32'(hazard),  32'd0);
        check("drain_seq",    32'(seq_bad), 32'd0);
        check("drain_err",    32'(err0),    32'd0);
        check("drain_iter",   32'(iter0),   32'd2);

        // Corrupted 5th write-back address
        clr_model();
        delay = 12;
        corrupt = 1'b1;
        start0 = 1'b1; cyc(); start0 = 1'b0;
        n = 0;
        while (n_wb < 5 && n < 200) begin cyc(); n++; end
        check("corrupt_wb_reached", 32'(n_wb), 32'd5);
        check("corrupt_err_before", 32'(err0), 32'd0);
        cyc();
        check("corrupt_err_next", 32'(err0), 32'd1);
        corrupt = 1'b0;
        wait_done0(1000);
        check("corrupt_err_sticky", 32'(err0),    32'd1);
        check("corrupt_iter",       32'(iter0),   32'd2);
        check("corrupt_reads",      32'(n_reads), 32'd80);
        cyc();

        // Reset during layer-1 ISSUE, then restart
        clr_model();
        start0 = 1'b1; cyc(); start0 = 1'b0;
        check("start_clears_err", 32'(err0), 32'd0);
        n = 0;
        while (!(rdenL0 === 1'b1 && rdl0 === 1'b1 && rda0 === AW'(5)) && n < 200) begin cyc(); n++; end
        check("reach_layer1", 32'(rdl0), 32'd1);
        rst = 1'b1;
        clr_req++;
        cyc();
        check("midrst_rden",  32'(rdenL0), 32'd0);
        check("midrst_rdenE", 32'(rdenE0), 32'd0);
        check("midrst_busy",  32'(busy0),  32'd0);
        check("midrst_layer", 32'(rdl0),   32'd0);
        check("midrst_addr",  32'(rda0),   32'd0);
        check("midrst_done",  32'(done0),  32'd0);
        check("midrst_err",   32'(err0),   32'd0);
        rst = 1'b0;
        repeat (20) cyc();
        check("idle_err_quiet", 32'(err0), 32'd0);
        start0 = 1'b1; cyc(); start0 = 1'b0;
        check("restart_rden",  32'(rdenL0), 32'd1);
        check("restart_addr",  32'(rda0),   32'd0);
        check("restart_layer", 32'(rdl0),   32'd0);
        wait_done0(1000);
        cyc();
        check("restart_reads", 32'(n_reads), 32'd80);
        check("restart_seq",   32'(seq_bad), 32'd0);
        check("restart_err",   32'(err0),    32'd0);
        check("restart_iter",  32'(iter0),   32'd2);

        // Stray write-back in IDLE
        stray_req++;
        repeat (3) cyc();
        check("stray_err",  32'(err0),  32'd1);
        check("stray_busy", 32'(busy0), 32'd0);

        // Iteration count on the MAXITER=8 instance; syndrome_ok during iteration 3
        clr_model();
        start0 = 1'b1; start1 = 1'b1; cyc(); start0 = 1'b0; start1 = 1'b0;
        check("start_clears_stray", 32'(err0), 32'd0);
        n = 0;
        while (iter1 !== 4'd2 && n < 1000) begin cyc(); n++; end
        check("iter1_reach2", 32'(iter1), 32'd2);
        syn1 = 1'b1;
        wait_done1(3000);
        syn1 = 1'b0;
`ifdef SCHED_EARLY_TERM_EN
        exp_iter = 3;
`else
        exp_iter = 8;
`endif
        check("iter1_count", 32'(iter1), 32'(exp_iter));
        cyc();
        check("iter1_reads", 32'(n_reads1), 32'(exp_iter * 40));
        check("iter1_seq",   32'(seq_bad1), 32'd0);
        check("iter1_ndone", 32'(n_done1),  32'd1);
        check("iter1_err",   32'(err1),     32'd0);
        check("inst0_ndone", 32'(n_done),   32'd1);
        check("inst0_err",   32'(err0),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
